key_expand: RTL and testbench

KEY_EXPAND -- requirements
Module: key_expand

---
 rtl/key_expand.sv | 156 +++++++++++++++
 tb/tb_key_expand.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/key_expand.sv
// AES-128 key expansion engine.
// Presents the eleven round keys one at a time over a valid/ready handshake,
// computing each next key in a single cycle from the key currently on display.

// Single-byte FIPS-197 S-box, built from the GF(2^8) inverse followed by the
// affine transform. This avoids a 256-entry table.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254. The chain maps 0 to 0, which is the
  // value the S-box definition needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] acc;
    logic [7:0] sq;
    acc = 8'h01;
    sq  = x;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv;

  // Inverse, then the affine transform b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  always_comb begin
    inv = gf_inv(a);
    y   = inv
        ^ {inv[6:0], inv[7]}
        ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]}
        ^ 8'h63;
  end

endmodule

module key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         rk_ready,
  output logic [127:0] roundkey,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    NEXT
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [127:0] work_q;
  logic [3:0]   round_q;
  logic [7:0]   rcon_q;
  logic         done_q;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot;
  logic [31:0]  sub;
  logic [31:0]  t;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon_nx;

  assign w0  = work_q[127:96];
  assign w1  = work_q[95:64];
  assign w2  = work_q[63:32];
  assign w3  = work_q[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  // One S-box per byte of the rotated last word.
  aes_sbox u_sbox0 (.a(rot[31:24]), .y(sub[31:24]));
  aes_sbox u_sbox1 (.a(rot[23:16]), .y(sub[23:16]));
  aes_sbox u_sbox2 (.a(rot[15:8]),  .y(sub[15:8]));
  aes_sbox u_sbox3 (.a(rot[7:0]),   .y(sub[7:0]));

  assign t  = sub ^ {rcon_q, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // xtime: doubling in GF(2^8).
  assign rcon_nx = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  // Next-state logic for the present/advance handshake loop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = PRESENT;
      PRESENT: if (rk_ready) state_nx = (round_q == 4'd10) ? IDLE : NEXT;
      NEXT:    state_nx = PRESENT;
      default: state_nx = IDLE;
    endcase
  end

  // State register, working key, round index, Rcon and the done pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state   <= IDLE;
      work_q  <= '0;
      round_q <= 4'd0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state == PRESENT) && rk_ready && (round_q == 4'd10);
      case (state)
        IDLE: begin
          if (start) begin
            work_q  <= key;
            round_q <= 4'd0;
            rcon_q  <= 8'h01;
          end
        end
        NEXT: begin
          work_q  <= {n0, n1, n2, n3};
          round_q <= round_q + 4'd1;
          rcon_q  <= rcon_nx;
        end
        default: ;
      endcase
    end
  end

  assign roundkey = work_q;
  assign rk_round = round_q;
  assign rk_valid = (state == PRESENT);
  assign busy     = (state != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_key_expand.sv
// Directed bench for key_expand: FIPS-197 and all-zero key schedules,
// back-pressure, start-while-busy, reset mid-run and back-to-back starts.
module tb_key_expand;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         rk_ready;
  logic [127:0] roundkey;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;

  int compared;
  int mismatched;

  logic [127:0] fips_key;
  logic [127:0] fips_rk [0:10];

  key_expand dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .rk_ready (rk_ready),
    .roundkey (roundkey),
    .rk_valid (rk_valid),
    .rk_round (rk_round),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Run a full FIPS-key expansion with rk_ready high, optionally stalling at
  // round 3 or pulsing a zero-key start at round 2. Returns in the done cycle.
  task automatic run_fips(input bit stall, input bit inject);
    key   = fips_key;
    start = 1'b1;
    tick();
    start = 1'b0;
    key   = '0;
    for (int r = 0; r <= 10; r++) begin
      check($sformatf("r%0d valid", r), {127'd0, rk_valid}, 128'd1);
      check($sformatf("r%0d index", r), {124'd0, rk_round}, r);
      check($sformatf("r%0d key", r), roundkey, fips_rk[r]);
      check($sformatf("r%0d busy", r), {127'd0, busy}, 128'd1);
      if (stall && r == 3) begin
        rk_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check($sformatf("stall%0d valid", s), {127'd0, rk_valid}, 128'd1);
          check($sformatf("stall%0d index", s), {124'd0, rk_round}, 128'd3);
          check($sformatf("stall%0d key", s), roundkey, fips_rk[3]);
        end
        rk_ready = 1'b1;
      end
      if (inject && r == 2) start = 1'b1;
      tick();
      start = 1'b0;
      if (r < 10) begin
        check($sformatf("r%0d gap", r), {127'd0, rk_valid}, 128'd0);
        check($sformatf("r%0d gap done", r), {127'd0, done}, 128'd0);
        tick();
      end
    end
    check("done pulse", {127'd0, done}, 128'd1);
    check("done busy", {127'd0, busy}, 128'd0);
    check("done valid", {127'd0, rk_valid}, 128'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    fips_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Reset, with start and rk_ready asserted to show reset wins.
    rst      = 1'b1;
    start    = 1'b1;
    key      = fips_key;
    rk_ready = 1'b1;
    tick();
    tick();
    check("reset valid", {127'd0, rk_valid}, 128'd0);
    check("reset busy", {127'd0, busy}, 128'd0);
    check("reset done", {127'd0, done}, 128'd0);
    check("reset index", {124'd0, rk_round}, 128'd0);
    check("reset key", roundkey, 128'd0);
    rst   = 1'b0;
    start = 1'b0;
    key   = '0;
    tick();
    check("idle valid", {127'd0, rk_valid}, 128'd0);

    // Plain FIPS-197 expansion.
    run_fips(1'b0, 1'b0);
    tick();
    check("done one cycle", {127'd0, done}, 128'd0);

    // All-zero key.
    key   = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero r0", roundkey, 128'd0);
    for (int r = 1; r <= 10; r++) begin
      tick();
      tick();
      check($sformatf("zero r%0d index", r), {124'd0, rk_round}, r);
      if (r == 1) check("zero r1", roundkey, 128'h62636363626363636263636362636363);
      if (r == 10) check("zero r10", roundkey, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    end
    tick();
    check("zero done", {127'd0, done}, 128'd1);
    tick();

    // Back-pressure at round 3.
    run_fips(1'b1, 1'b0);
    tick();

    // Zero-key start pulsed while busy.
    run_fips(1'b0, 1'b1);
    tick();

    // Reset at round 5.
    key   = fips_key;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid index", {124'd0, rk_round}, 128'd5);
    check("mid key", roundkey, fips_rk[5]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst valid", {127'd0, rk_valid}, 128'd0);
    check("mid rst busy", {127'd0, busy}, 128'd0);
    check("mid rst key", roundkey, 128'd0);
    check("mid rst done", {127'd0, done}, 128'd0);
    tick();
    check("post rst valid", {127'd0, rk_valid}, 128'd0);
    check("post rst done", {127'd0, done}, 128'd0);

    // Fresh expansion, then start in its done cycle.
    run_fips(1'b0, 1'b0);
    key   = fips_key;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b valid", {127'd0, rk_valid}, 128'd1);
    check("b2b index", {124'd0, rk_round}, 128'd0);
    check("b2b key", roundkey, fips_rk[0]);
    begin
      int cycles;
      cycles = 0;
      while (!done && cycles < 40) begin
        tick();
        cycles++;
      end
      check("b2b done latency", cycles, 128'd21);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
